// File: rtl/demux2_32b_buf.sv
// Routes one input stream to two output ports, each with its own small FIFO.
// Every word delivered on a port bumps a saturating per-port counter.
module demux2_32b_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sel,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [15:0]      cnt1,
    output logic [15:0]      cnt2
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] OCC_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] OCC_ONE  = (PW+1)'(1);

    logic [WIDTH-1:0] mem_q  [2][DEPTH];
    logic [PW-1:0]    wptr_q [2];
    logic [PW-1:0]    wptr_d [2];
    logic [PW-1:0]    rptr_q [2];
    logic [PW-1:0]    rptr_d [2];
    logic [PW:0]      occ_q  [2];
    logic [PW:0]      occ_d  [2];
    logic [15:0]      cnt_q  [2];
    logic [15:0]      cnt_d  [2];
    logic             push_s [2];
    logic             pop_s  [2];
    logic [1:0]       out_ready_s;
    logic             in_ready_s;

    assign out_ready_s = {out2_ready, out1_ready};

    // Acceptance looks only at the addressed FIFO, never at the consumers.
    always_comb begin
        in_ready_s = 1'b0;
        if (in_sel) begin
            in_ready_s = (occ_q[1] != OCC_FULL);
        end else begin
            in_ready_s = (occ_q[0] != OCC_FULL);
        end
    end

    // Next-state for pointers, occupancy and delivery counters of both FIFOs.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            push_s[p] = in_valid && in_ready_s && (in_sel == 1'(p));
            pop_s[p]  = (occ_q[p] != '0) && out_ready_s[p];
            wptr_d[p] = push_s[p] ? (wptr_q[p] + 1'b1) : wptr_q[p];
            rptr_d[p] = pop_s[p]  ? (rptr_q[p] + 1'b1) : rptr_q[p];
            case ({push_s[p], pop_s[p]})
                2'b10:   occ_d[p] = occ_q[p] + OCC_ONE;
                2'b01:   occ_d[p] = occ_q[p] - OCC_ONE;
                default: occ_d[p] = occ_q[p];
            endcase
            if (pop_s[p] && (cnt_q[p] != 16'hFFFF)) begin
                cnt_d[p] = cnt_q[p] + 16'd1;
            end else begin
                cnt_d[p] = cnt_q[p];
            end
        end
    end

    // Storage needs no reset: stale entries are masked by zero occupancy.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push_s[p]) begin
                mem_q[p][wptr_q[p]] <= in_data;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                wptr_q[p] <= '0;
                rptr_q[p] <= '0;
                occ_q[p]  <= '0;
                cnt_q[p]  <= 16'd0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                wptr_q[p] <= wptr_d[p];
                rptr_q[p] <= rptr_d[p];
                occ_q[p]  <= occ_d[p];
                cnt_q[p]  <= cnt_d[p];
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out1_valid = (occ_q[0] != '0);
    assign out2_valid = (occ_q[1] != '0);
    assign out1_data  = out1_valid ? mem_q[0][rptr_q[0]] : {WIDTH{1'b0}};
    assign out2_data  = out2_valid ? mem_q[1][rptr_q[1]] : {WIDTH{1'b0}};
    assign cnt1       = cnt_q[0];
    assign cnt2       = cnt_q[1];

endmodule

// File: tb/tb_demux2_32b_buf.sv
// Directed bench for demux2_32b_buf: routing, backpressure, concurrency,
// long wrap/saturation stream and mid-stream reset.
module tb_demux2_32b_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_sel;
    logic        in_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [31:0] out2_data;
    logic        out2_valid;
    logic        out2_ready;
    logic [15:0] cnt1;
    logic [15:0] cnt2;

    int total = 0;
    int bad   = 0;

    demux2_32b_buf #(.WIDTH(32), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_sel(in_sel), .in_ready(in_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
        .cnt1(cnt1), .cnt2(cnt2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int occ2;
        int pushed;
        int popped;
        int errs;
        logic exp_rdy;
        logic do_push;
        logic do_pop;

        rst_n = 1'b0; in_data = 32'd0; in_valid = 1'b0; in_sel = 1'b0;
        out1_ready = 1'b0; out2_ready = 1'b0;
        tick(); tick();
        check("rst_v1", 32'(out1_valid), 32'd0);
        check("rst_v2", 32'(out2_valid), 32'd0);
        check("rst_d1", out1_data, 32'd0);
        check("rst_cnt", 32'({cnt1, cnt2}), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Routing
        out1_ready = 1'b1; out2_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h00000001;
        tick();
        in_sel = 1'b1; in_data = 32'h00000002;
        #1;
        check("rt_v1", 32'(out1_valid), 32'd1);
        check("rt_d1", out1_data, 32'h00000001);
        check("rt_v2_early", 32'(out2_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        #1;
        check("rt_v1_gone", 32'(out1_valid), 32'd0);
        check("rt_d1_zero", out1_data, 32'd0);
        check("rt_d2", out2_data, 32'h00000002);
        check("rt_cnt1", 32'(cnt1), 32'd1);
        tick();
        check("rt_v2_gone", 32'(out2_valid), 32'd0);
        check("rt_cnt2", 32'(cnt2), 32'd1);

        // Backpressure
        out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        in_data = 32'hC;
        #1;
        check("bp_rdy_full", 32'(in_ready), 32'd0);
        in_sel = 1'b1;
        #1;
        check("bp_rdy_other", 32'(in_ready), 32'd1);
        in_sel = 1'b0;
        tick();
        check("bp_head_a", out1_data, 32'hA);
        check("bp_rdy_still", 32'(in_ready), 32'd0);
        out1_ready = 1'b1;
        #1;
        check("bp_rdy_pop_full", 32'(in_ready), 32'd0);
        tick();
        check("bp_head_b", out1_data, 32'hB);
        check("bp_rdy_space", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("bp_head_c", out1_data, 32'hC);
        tick();
        check("bp_empty", 32'(out1_valid), 32'd0);
        check("bp_cnt1", 32'(cnt1), 32'd4);

        // Concurrency
        out1_ready = 1'b0; out2_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hD0;
        tick();
        in_sel = 1'b1; in_data = 32'hE0;
        tick();
        in_sel = 1'b0; in_data = 32'hF0;
        out1_ready = 1'b1; out2_ready = 1'b1;
        #1;
        check("cc_d1_pre", out1_data, 32'hD0);
        check("cc_d2_pre", out2_data, 32'hE0);
        check("cc_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("cc_v1", 32'(out1_valid), 32'd1);
        check("cc_d1", out1_data, 32'hF0);
        check("cc_v2", 32'(out2_valid), 32'd0);
        check("cc_cnt1", 32'(cnt1), 32'd5);
        tick();
        check("cc_v1_end", 32'(out1_valid), 32'd0);
        check("cc_cnt1_end", 32'(cnt1), 32'd6);
        check("cc_cnt2_idle_ready", 32'(cnt2), 32'd2);

        // Long stream to port 2: wrap and counter saturation
        out1_ready = 1'b0;
        occ2 = 0; pushed = 0; popped = 0; errs = 0;
        for (int c = 0; c < 90000 && popped < 70000; c++) begin
            in_valid = (pushed < 70000);
            in_sel = 1'b1;
            in_data = 32'(pushed);
            out2_ready = ((c % 16) != 15);
            #1;
            exp_rdy = (occ2 < 2);
            do_push = in_valid && exp_rdy;
            do_pop  = (occ2 != 0) && out2_ready;
            if (in_ready !== exp_rdy) errs++;
            if (out2_valid !== (occ2 != 0)) errs++;
            if (do_pop) begin
                if (out2_data !== 32'(popped)) begin
                    if (errs < 3) $display("stream word %0d got %h", popped, out2_data);
                    errs++;
                end
                popped++;
            end
            if (do_push) pushed++;
            occ2 = occ2 + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
            tick();
        end
        in_valid = 1'b0;
        check("st_errs", 32'(errs), 32'd0);
        check("st_popped", 32'(popped), 32'd70000);
        check("st_cnt2_sat", 32'(cnt2), 32'h0000FFFF);
        check("st_v2_end", 32'(out2_valid), 32'd0);

        // Mid-stream reset with both FIFOs full
        out1_ready = 1'b0; out2_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        in_sel = 1'b1; in_data = 32'h33;
        tick();
        in_data = 32'h44;
        tick();
        in_valid = 1'b0;
        #1;
        check("mr_full2", 32'(in_ready), 32'd0);
        check("mr_head1", out1_data, 32'h11);
        rst_n = 1'b0;
        #1;
        check("mr_v1", 32'(out1_valid), 32'd0);
        check("mr_v2", 32'(out2_valid), 32'd0);
        check("mr_d2", out2_data, 32'd0);
        check("mr_cnt", 32'({cnt1, cnt2}), 32'd0);
        check("mr_rdy", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h55;
        tick();
        in_valid = 1'b0;
        #1;
        check("mr_first", out1_data, 32'h55);
        check("mr_v2_post", 32'(out2_valid), 32'd0);
        out1_ready = 1'b1;
        tick();
        check("mr_no_stale", 32'(out1_valid), 32'd0);
        check("mr_cnt1", 32'(cnt1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
